mda_motor_ramp_controller: RTL and testbench
============================================

MDA_MOTOR_RAMP_CONTROLLER -- requirements
Module: mda_motor_ramp_controller

Interface
REQ-001 Parameter PWM_PERIOD, default 1000, PWM period in clk cycles; legal range 2..1023.
REQ-002 Parameter RAMP_DIV, default 1000, clk cycles per 1-count duty step; legal range 1..65535.
REQ-003 Parameter COAST_CYCLES, default 2000, clk cycles with bridge off before a direction reversal; legal range 1..65535.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cmd_valid  input  1  command offered this cycle.
REQ-007 cmd_ready  output  1  controller accepts a command this cycle.
REQ-008 cmd_dir  input  1  requested direction.
REQ-009 cmd_duty  input  10  requested duty in clk cycles per PWM period.
REQ-010 dir  output  1  direction to the H-bridge driver.
REQ-011 on  output  1  PWM enable to the H-bridge driver.
REQ-012 busy  output  1  high whenever state is not STEADY.
REQ-013 cur_duty  output  10  present ramped duty.

Function
REQ-014 A command is accepted on a cycle with cmd_valid=1 and cmd_ready=1; it overwrites the target (tgt_dir, tgt_duty) and takes effect the next cycle.
REQ-015 cmd_duty > PWM_PERIOD is clamped to PWM_PERIOD at acceptance.
REQ-016 cmd_ready=1 in all states except COAST, where it is 0.
REQ-017 States: STEADY, RAMP, RAMP_DOWN, COAST.
REQ-018 STEADY means cur_duty==tgt_duty and cur_dir==tgt_dir.
REQ-019 STEADY->RAMP on a target change with tgt_dir==cur_dir, or with cur_duty==0.
  - With cur_duty==0, cur_dir is loaded from tgt_dir immediately and no coast is applied.
REQ-020 STEADY or RAMP->RAMP_DOWN on tgt_dir!=cur_dir with cur_duty>0.
REQ-021 Ramp prescaler:
  - free-running, 16 bits, counts 0..RAMP_DIV-1 and wraps;
  - the wrap cycle is a ramp tick.
REQ-022 In RAMP, each tick moves cur_duty by exactly 1 toward tgt_duty; RAMP->STEADY when they become equal.
REQ-023 In RAMP_DOWN, each tick decrements cur_duty by 1; on reaching 0 -> COAST.
REQ-024 A command accepted in RAMP_DOWN with cmd_dir==cur_dir aborts the reversal -> RAMP toward the new duty.
REQ-025 COAST:
  - lasts exactly COAST_CYCLES cycles, counted by a 16-bit counter;
  - then cur_dir<=tgt_dir and -> RAMP, or -> STEADY if tgt_duty==0.
REQ-026 PWM counter: 10 bits, 0..PWM_PERIOD-1, wraps; free-running.
REQ-027 on is registered: on <= (pwm_cnt < cur_duty) in STEADY/RAMP/RAMP_DOWN, and 0 in COAST.
  - cur_duty==0 gives on constantly 0.
  - cur_duty==PWM_PERIOD gives on constantly 1.
REQ-028 dir is registered: dir <= cur_dir, except 0 in COAST (driver fully off, not braking).
REQ-029 Output latency: one clk from state/counter to dir/on.
REQ-030 Tick and command on the same cycle: the tick uses the old target; the new target applies from the next cycle.
REQ-031 cur_duty never exceeds PWM_PERIOD and never underflows below 0.

Reset
REQ-032 On reset:
  - state=STEADY; cur_duty=0, cur_dir=0, tgt_duty=0, tgt_dir=0;
  - pwm, prescaler and coast counters = 0;
  - dir=0, on=0, busy=0, cmd_ready=1.
REQ-033 Reset asserted mid-ramp or mid-coast takes effect on the next clk edge and discards the pending target.

Structure
REQ-034 State encoding and the parameter defaults live in the shared mda_motor_control_defines file.
REQ-035 PWM counter plus comparator is one sub-module, mda_motor_pwm_gen (inputs duty, enable; output on).
REQ-036 dir/on connect directly to the existing H-bridge driver's dir/on inputs; dead-time insertion remains in that driver.

Verification
Bench parameters: PWM_PERIOD=10, RAMP_DIV=4, COAST_CYCLES=8.
REQ-037 Reset, then cmd (dir=0, duty=5) -> cur_duty steps 1..5, one step per 4 cycles; busy falls when cur_duty=5; on high 5 of every 10 cycles.
REQ-038 From STEADY (dir=0, duty=3), cmd (dir=1, duty=2):
  - ramp down to 0, then dir=0/on=0 for exactly 8 cycles with cmd_ready=0;
  - then dir=1 and ramp 1..2.
REQ-039 Command (dir=1, duty=15) -> clamped; cur_duty settles at 10; on constantly 1.
REQ-040 During RAMP_DOWN at cur_duty=2, cmd (dir=0, duty=6) -> no COAST; cur_duty ramps 2..6 with dir=0.
REQ-041 Reset asserted during COAST -> next cycle all outputs at reset values, cmd_ready=1, cur_duty=0.
REQ-042 Command accepted on a tick cycle -> that tick moves toward the old target; subsequent ticks move toward the new target.

Source files
------------

// File: rtl/mda_motor_ramp_controller_pkg.sv
// ----------------------------------------------------------------------------
// mda_motor_ramp_controller_pkg
// Shared motor-control definitions: parameter defaults, counter widths,
// controller state encoding and a duty clamp helper.
// No ports (package).
// ----------------------------------------------------------------------------
package mda_motor_ramp_controller_pkg;

  // Parameter defaults
  localparam int DEF_PWM_PERIOD   = 1000;
  localparam int DEF_RAMP_DIV     = 1000;
  localparam int DEF_COAST_CYCLES = 2000;

  // Counter / datapath widths
  localparam int DUTY_W  = 10;
  localparam int PRESC_W = 16;
  localparam int COAST_W = 16;

  typedef logic [DUTY_W-1:0] duty_t;

  // Controller state encoding
  localparam logic [1:0] ST_STEADY    = 2'd0;
  localparam logic [1:0] ST_RAMP      = 2'd1;
  localparam logic [1:0] ST_RAMP_DOWN = 2'd2;
  localparam logic [1:0] ST_COAST     = 2'd3;

  // Limit a requested duty to the PWM period.
  function automatic duty_t clamp_duty(input duty_t duty, input duty_t limit);
    return (duty > limit) ? limit : duty;
  endfunction

endpackage

// File: rtl/mda_motor_pwm_gen.sv
// ----------------------------------------------------------------------------
// mda_motor_pwm_gen
// Free-running PWM counter (0..PWM_PERIOD-1) plus comparator. The on output
// is registered: on <= enable && (pwm_cnt < duty).
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-high reset
//   duty   in   high cycles per PWM period (0..PWM_PERIOD)
//   enable in   0 forces on low (bridge off)
//   on     out  registered PWM enable
// ----------------------------------------------------------------------------
module mda_motor_pwm_gen
  import mda_motor_ramp_controller_pkg::*;
#(
  parameter int PWM_PERIOD = DEF_PWM_PERIOD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DUTY_W-1:0] duty,
  input  logic              enable,
  output logic              on
);

  localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PWM_PERIOD - 1);

  logic [DUTY_W-1:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt <= '0;
      on      <= 1'b0;
    end else begin
      pwm_cnt <= (pwm_cnt == CNT_LAST) ? '0 : pwm_cnt + 1'b1;
      // duty == PWM_PERIOD exceeds every count value, so on stays high.
      on      <= enable && (pwm_cnt < duty);
    end
  end

endmodule

// File: rtl/mda_motor_ramp_controller.sv
// ----------------------------------------------------------------------------
// mda_motor_ramp_controller
// Ramps the H-bridge PWM duty toward a commanded target one count per ramp
// tick. A direction reversal ramps down to zero, coasts with the bridge off
// for COAST_CYCLES, then ramps up in the new direction.
//
// Handshake: a command transfers on a cycle where cmd_valid && cmd_ready.
// cmd_ready is low only while coasting; cmd_valid may be held across that
// window and the command is taken once cmd_ready returns. An accepted command
// overwrites the target; the state machine acts on it from the next cycle.
//
// Ports:
//   clk        in   clock
//   reset      in   synchronous active-high reset
//   cmd_valid  in   command offered
//   cmd_ready  out  command accepted this cycle if cmd_valid
//   cmd_dir    in   requested direction
//   cmd_duty   in   requested duty (clamped to PWM_PERIOD)
//   dir        out  registered direction to the H-bridge driver (0 in COAST)
//   on         out  registered PWM enable to the H-bridge driver
//   busy       out  state is not STEADY
//   cur_duty   out  present ramped duty
//   state_dbg  out  controller state (debug observation)
// ----------------------------------------------------------------------------
module mda_motor_ramp_controller
  import mda_motor_ramp_controller_pkg::*;
#(
  parameter int PWM_PERIOD   = DEF_PWM_PERIOD,
  parameter int RAMP_DIV     = DEF_RAMP_DIV,
  parameter int COAST_CYCLES = DEF_COAST_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [DUTY_W-1:0] cmd_duty,
  output logic              dir,
  output logic              on,
  output logic              busy,
  output logic [DUTY_W-1:0] cur_duty,
  output logic [1:0]        state_dbg
);

  localparam logic [DUTY_W-1:0]  PERIOD_DUTY = DUTY_W'(PWM_PERIOD);
  localparam logic [PRESC_W-1:0] PRESC_LAST  = PRESC_W'(RAMP_DIV - 1);
  localparam logic [COAST_W-1:0] COAST_LAST  = COAST_W'(COAST_CYCLES - 1);

  logic [1:0]         state;
  logic               cur_dir;
  logic               tgt_dir;
  logic [DUTY_W-1:0]  tgt_duty;
  logic [DUTY_W-1:0]  duty_step;
  logic [PRESC_W-1:0] presc;
  logic [COAST_W-1:0] coast_cnt;
  logic               ramp_tick;
  logic               cmd_accept;
  logic               dir_mismatch;
  logic               pwm_enable;

  assign cmd_ready    = (state != ST_COAST);
  assign cmd_accept   = cmd_valid && cmd_ready;
  assign busy         = (state != ST_STEADY);
  assign state_dbg    = state;
  assign ramp_tick    = (presc == PRESC_LAST);
  assign dir_mismatch = (tgt_dir != cur_dir);
  assign pwm_enable   = (state != ST_COAST);

  // One count toward the target; only used when the two differ.
  assign duty_step = (tgt_duty > cur_duty) ? cur_duty + 1'b1 : cur_duty - 1'b1;

  // Free-running ramp prescaler; the wrap cycle is the ramp tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
    end else begin
      presc <= ramp_tick ? '0 : presc + 1'b1;
    end
  end

  // Target register and ramp state machine. The FSM reads the registered
  // target, so a command arriving on a tick cycle only affects later ticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_STEADY;
      cur_duty  <= '0;
      cur_dir   <= 1'b0;
      tgt_duty  <= '0;
      tgt_dir   <= 1'b0;
      coast_cnt <= '0;
    end else begin
      if (cmd_accept) begin
        tgt_dir  <= cmd_dir;
        tgt_duty <= clamp_duty(cmd_duty, PERIOD_DUTY);
      end

      case (state)
        ST_STEADY: begin
          if (dir_mismatch && (cur_duty != '0)) begin
            state <= ST_RAMP_DOWN;
          end else if (dir_mismatch || (tgt_duty != cur_duty)) begin
            // At zero duty a direction change needs no coast.
            cur_dir <= tgt_dir;
            state   <= ST_RAMP;
          end
        end

        ST_RAMP: begin
          if (dir_mismatch) begin
            if (cur_duty != '0) begin
              state <= ST_RAMP_DOWN;
            end else begin
              cur_dir <= tgt_dir;
            end
          end else if (cur_duty == tgt_duty) begin
            state <= ST_STEADY;
          end else if (ramp_tick) begin
            cur_duty <= duty_step;
            if (duty_step == tgt_duty) begin
              state <= ST_STEADY;
            end
          end
        end

        ST_RAMP_DOWN: begin
          if (!dir_mismatch) begin
            // New command restored the present direction: abort reversal.
            state <= ST_RAMP;
          end else if (cur_duty == '0) begin
            state     <= ST_COAST;
            coast_cnt <= '0;
          end else if (ramp_tick) begin
            cur_duty <= cur_duty - 1'b1;
            if (cur_duty == DUTY_W'(1)) begin
              state     <= ST_COAST;
              coast_cnt <= '0;
            end
          end
        end

        ST_COAST: begin
          // Counts 0..COAST_CYCLES-1, so COAST lasts exactly COAST_CYCLES.
          if (coast_cnt == COAST_LAST) begin
            coast_cnt <= '0;
            cur_dir   <= tgt_dir;
            state     <= (tgt_duty == '0) ? ST_STEADY : ST_RAMP;
          end else begin
            coast_cnt <= coast_cnt + 1'b1;
          end
        end

        default: begin
          state <= ST_STEADY;
        end
      endcase
    end
  end

  // Direction to the driver; forced low while coasting so the bridge is
  // fully off rather than braking.
  always_ff @(posedge clk) begin
    if (reset) begin
      dir <= 1'b0;
    end else begin
      dir <= (state == ST_COAST) ? 1'b0 : cur_dir;
    end
  end

  mda_motor_pwm_gen #(
    .PWM_PERIOD (PWM_PERIOD)
  ) u_pwm_gen (
    .clk    (clk),
    .reset  (reset),
    .duty   (cur_duty),
    .enable (pwm_enable),
    .on     (on)
  );

endmodule

// File: tb/tb_mda_motor_ramp_controller.sv
// ----------------------------------------------------------------------------
// tb_mda_motor_ramp_controller
// Directed scenarios plus randomized commands/resets, checked every cycle
// against a behavioural model of the controller rules.
// ----------------------------------------------------------------------------
module tb_mda_motor_ramp_controller;
  import mda_motor_ramp_controller_pkg::*;

  localparam int PWM_PERIOD   = 10;
  localparam int RAMP_DIV     = 4;
  localparam int COAST_CYCLES = 8;
  localparam int EXP_W        = 14;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_dir = 1'b0;
  logic [9:0] cmd_duty = '0;
  logic       cmd_ready;
  logic       dir;
  logic       on;
  logic       busy;
  logic [9:0] cur_duty;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  mda_motor_ramp_controller #(
    .PWM_PERIOD   (PWM_PERIOD),
    .RAMP_DIV     (RAMP_DIV),
    .COAST_CYCLES (COAST_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_duty  (cmd_duty),
    .dir       (dir),
    .on        (on),
    .busy      (busy),
    .cur_duty  (cur_duty),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [EXP_W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Phases: HOLD (settled), SLEW (moving toward target), UNWIND (decaying to
  // zero before a reversal), OFF (bridge off, waiting to reverse).
  typedef enum int {P_HOLD, P_SLEW, P_UNWIND, P_OFF} phase_t;
  phase_t m_phase = P_HOLD;
  int m_duty, m_dir, m_tgt_duty, m_tgt_dir, m_off_left, m_n, m_on, m_dir_out;

  task automatic model_step(input logic r, input logic v, input logic d, input logic [9:0] du);
    phase_t nph;
    int nd, ndir, tick;
    if (r) begin
      m_phase = P_HOLD; m_duty = 0; m_dir = 0; m_tgt_duty = 0; m_tgt_dir = 0;
      m_off_left = 0; m_n = 0; m_on = 0; m_dir_out = 0;
    end else begin
      nph  = m_phase;
      nd   = m_duty;
      ndir = m_dir;
      // Edge number m_n+1: prescaler and PWM counter are plain modulo counts.
      tick = ((m_n % RAMP_DIV) == RAMP_DIV - 1) ? 1 : 0;
      m_on      = (m_phase != P_OFF && (m_n % PWM_PERIOD) < m_duty) ? 1 : 0;
      m_dir_out = (m_phase == P_OFF) ? 0 : m_dir;
      case (m_phase)
        P_HOLD: begin
          if (m_tgt_dir != m_dir && m_duty > 0) nph = P_UNWIND;
          else if (m_tgt_dir != m_dir || m_tgt_duty != m_duty) begin
            ndir = m_tgt_dir; nph = P_SLEW;
          end
        end
        P_SLEW: begin
          if (m_tgt_dir != m_dir) begin
            if (m_duty > 0) nph = P_UNWIND; else ndir = m_tgt_dir;
          end else if (m_duty == m_tgt_duty) nph = P_HOLD;
          else if (tick == 1) begin
            nd = (m_tgt_duty > m_duty) ? m_duty + 1 : m_duty - 1;
            if (nd == m_tgt_duty) nph = P_HOLD;
          end
        end
        P_UNWIND: begin
          if (m_tgt_dir == m_dir) nph = P_SLEW;
          else if (m_duty == 0) begin nph = P_OFF; m_off_left = COAST_CYCLES; end
          else if (tick == 1) begin
            nd = m_duty - 1;
            if (nd == 0) begin nph = P_OFF; m_off_left = COAST_CYCLES; end
          end
        end
        P_OFF: begin
          m_off_left--;
          if (m_off_left == 0) begin
            ndir = m_tgt_dir;
            nph  = (m_tgt_duty == 0) ? P_HOLD : P_SLEW;
          end
        end
        default: nph = P_HOLD;
      endcase
      if (v && m_phase != P_OFF) begin
        m_tgt_dir  = d;
        m_tgt_duty = (du > PWM_PERIOD) ? PWM_PERIOD : du;
      end
      m_phase = nph; m_duty = nd; m_dir = ndir;
      m_n++;
    end
    exp_q.push_back({1'(m_dir_out), 1'(m_on), (m_phase != P_HOLD), (m_phase != P_OFF), 10'(m_duty)});
  endtask

  // ---------------- driver ----------------
  // Called at a negedge: check what the last posedge produced, drive the
  // next inputs, advance the model, move to the next negedge.
  task automatic run_cycle(input logic r, input logic v, input logic d, input logic [9:0] du);
    logic [EXP_W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("cur_duty",  cur_duty,  e[9:0]);
      check_eq("cmd_ready", cmd_ready, e[10]);
      check_eq("busy",      busy,      e[11]);
      check_eq("on",        on,        e[12]);
      check_eq("dir",       dir,       e[13]);
    end
    reset = r; cmd_valid = v; cmd_dir = d; cmd_duty = du;
    model_step(r, v, d, du);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 1'b0, 1'b0, 10'd0);
  endtask

  task automatic send(input logic d, input logic [9:0] du);
    run_cycle(1'b0, 1'b1, d, du);
  endtask

  // ---------------- stimulus ----------------
  int on_cnt, lo_cnt, min_duty, dir_hi, d0;
  bit found;

  initial begin
    @(negedge clk);
    run_cycle(1'b1, 1'b0, 1'b0, 10'd0);
    run_cycle(1'b1, 1'b0, 1'b0, 10'd0);
    check_eq("rst_duty", cur_duty, 0);
    check_eq("rst_dir", dir, 0);
    check_eq("rst_on", on, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", cmd_ready, 1);
    check_eq("rst_state", state_dbg, ST_STEADY);

    // Ramp up to 5 in direction 0
    send(1'b0, 10'd5);
    idle(40);
    check_eq("up5_duty", cur_duty, 5);
    check_eq("up5_busy", busy, 0);
    on_cnt = 0;
    for (int i = 0; i < 10; i++) begin on_cnt += on; idle(1); end
    check_eq("up5_on_cnt", on_cnt, 5);

    // Settle at 3, then reverse to (1,2)
    send(1'b0, 10'd3);
    idle(20);
    check_eq("dn3_duty", cur_duty, 3);
    send(1'b1, 10'd2);
    lo_cnt = 0;
    for (int i = 0; i < 60; i++) begin lo_cnt += (cmd_ready == 1'b0); idle(1); end
    check_eq("rev_coast_len", lo_cnt, COAST_CYCLES);
    check_eq("rev_dir", dir, 1);
    check_eq("rev_duty", cur_duty, 2);

    // Clamp: 15 -> 10, on constantly high
    send(1'b1, 10'd15);
    idle(50);
    check_eq("clamp_duty", cur_duty, 10);
    on_cnt = 0;
    for (int i = 0; i < 10; i++) begin on_cnt += on; idle(1); end
    check_eq("clamp_on_cnt", on_cnt, 10);

    // Abort a reversal at duty 2
    send(1'b0, 10'd4);
    idle(100);
    check_eq("pre_abort_duty", cur_duty, 4);
    send(1'b1, 10'd5);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (m_phase == P_UNWIND && m_duty == 2) found = 1; else idle(1);
    end
    check_eq("abort_reach2", found, 1);
    send(1'b0, 10'd6);
    min_duty = 99; lo_cnt = 0; dir_hi = 0;
    for (int i = 0; i < 40; i++) begin
      if (cur_duty < min_duty) min_duty = cur_duty;
      lo_cnt += (cmd_ready == 1'b0);
      dir_hi += dir;
      idle(1);
    end
    check_eq("abort_min", min_duty, 2);
    check_eq("abort_no_coast", lo_cnt, 0);
    check_eq("abort_dir", dir_hi, 0);
    check_eq("abort_duty", cur_duty, 6);

    // Command on a tick cycle
    send(1'b0, 10'd9);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (m_phase == P_SLEW && m_duty == 7 && (m_n % RAMP_DIV) == RAMP_DIV - 1) found = 1;
      else idle(1);
    end
    check_eq("tick_cmd_found", found, 1);
    d0 = m_duty;
    send(1'b0, 10'd2);
    check_eq("tick_old_tgt", cur_duty, d0 + 1);
    idle(4);
    check_eq("tick_new_tgt", cur_duty, d0);
    idle(40);

    // Reset during COAST
    send(1'b1, 10'd3);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (m_phase == P_OFF) found = 1; else idle(1);
    end
    check_eq("coast_found", found, 1);
    idle(3);
    run_cycle(1'b1, 1'b0, 1'b0, 10'd0);
    check_eq("coast_rst_dir", dir, 0);
    check_eq("coast_rst_on", on, 0);
    check_eq("coast_rst_busy", busy, 0);
    check_eq("coast_rst_ready", cmd_ready, 1);
    check_eq("coast_rst_duty", cur_duty, 0);
    idle(20);
    check_eq("coast_rst_discard", cur_duty, 0);
    check_eq("coast_rst_idle", busy, 0);

    // Randomized commands and occasional resets
    for (int i = 0; i < 1500; i++) begin
      bit rr, vv, dd;
      logic [9:0] du;
      rr = ($urandom_range(0, 299) == 0);
      vv = ($urandom_range(0, 19) == 0);
      dd = 1'($urandom_range(0, 1));
      du = 10'($urandom_range(0, 15));
      run_cycle(rr, vv, dd, du);
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
